snn_timestep_scheduler: RTL and testbench

Sequences one SNN inference run. Clears the IF network, then steps the spike generator through N timesteps with a programmable settle window per step. Accumulates each output neuron's spikes into saturating counters and reports completion. Sits between the AXI config registers (start/abort/config/readback) and the spike_generator, if_network and spike-count path. It drives their snn_rst and the per-step strobes.

---
 rtl/snn_sched_pkg.sv | 23 ++
 rtl/snn_sat_counter_bank.sv | 49 ++++
 rtl/snn_timestep_scheduler.sv | 161 ++++++++++++++++
 tb/tb_snn_timestep_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/snn_sched_pkg.sv
// Shared types, default widths and the index-width helper for the SNN timestep scheduler.
package snn_sched_pkg;

    localparam int DEF_NUM_OUTPUTS  = 1;
    localparam int DEF_STEP_W       = 16;
    localparam int DEF_SETTLE_W     = 8;
    localparam int DEF_COUNT_W      = 8;
    localparam int DEF_CLEAR_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STEP   = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } sched_state_t;

    // One spare bit so that an out-of-range select is always representable.
    function automatic int idx_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/snn_sat_counter_bank.sv
// Bank of per-neuron saturating spike counters with synchronous clear and a combinational read mux.
// Counts update one cycle after a spike; readback is zero-latency and returns 0 for an out-of-range index.
module snn_sat_counter_bank
    import snn_sched_pkg::*;
#(
    parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS,
    parameter int COUNT_W     = DEF_COUNT_W,
    localparam int IDX_W      = idx_w(NUM_OUTPUTS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_clear,
    input  logic                                i_en,
    input  logic [NUM_OUTPUTS-1:0]              i_spike,
    input  logic [IDX_W-1:0]                    i_rd_idx,
    output logic [COUNT_W-1:0]                  o_rd_data,
    output logic [NUM_OUTPUTS-1:0][COUNT_W-1:0] o_cnt_all
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic [NUM_OUTPUTS-1:0][COUNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                if (i_spike[i] && (r_cnt[i] != CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (i_rd_idx == IDX_W'(i)) begin
                o_rd_data = r_cnt[i];
            end
        end
    end

    assign o_cnt_all = r_cnt;

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Runs one SNN inference: clear the network, strobe N timesteps with a settle window each, count output spikes.
// Optional argmax winner report is enabled by defining SNN_SCHED_WINNER_EN.
module snn_timestep_scheduler
    import snn_sched_pkg::*;
#(
    parameter int NUM_OUTPUTS  = DEF_NUM_OUTPUTS,
    parameter int STEP_W       = DEF_STEP_W,
    parameter int SETTLE_W     = DEF_SETTLE_W,
    parameter int COUNT_W      = DEF_COUNT_W,
    parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES,
    localparam int IDX_W       = idx_w(NUM_OUTPUTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [STEP_W-1:0]      num_steps,
    input  logic [SETTLE_W-1:0]    settle_cycles,
    output logic                   snn_rst,
    output logic                   step_en,
    output logic [STEP_W-1:0]      mem_addr,
    input  logic [NUM_OUTPUTS-1:0] spike_out,
    input  logic [IDX_W-1:0]       cnt_rd_idx,
    output logic [COUNT_W-1:0]     cnt_rd_data,
    output logic [STEP_W-1:0]      step_count,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       winner_idx,
    output logic                   winner_valid
);

    localparam int CLR_W = idx_w(CLEAR_CYCLES);

    sched_state_t        r_state;
    sched_state_t        w_state_nxt;
    logic [STEP_W-1:0]   r_num_steps;
    logic [SETTLE_W-1:0] r_settle;
    logic [STEP_W-1:0]   r_step_count;
    logic [CLR_W-1:0]    r_clr_cnt;
    logic [SETTLE_W-1:0] r_settle_cnt;

    logic                w_start_acc;
    logic                w_abort;
    logic                w_step_done;
    logic                w_run_last;
    logic                w_acc_en;
    logic [STEP_W-1:0]   w_step_next;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_abort     = (r_state != IDLE) && abort;
    assign w_step_next = r_step_count + 1'b1;
    assign w_run_last  = (w_step_next == r_num_steps);
    assign w_step_done = ((r_state == STEP) && (r_settle == '0)) ||
                         ((r_state == SETTLE) && (r_settle_cnt == r_settle - SETTLE_W'(1)));
    // The abort cycle's spikes are deliberately dropped.
    assign w_acc_en    = ((r_state == STEP) || (r_state == SETTLE)) && !abort;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = CLEAR;
            CLEAR:   if (r_clr_cnt == CLR_W'(CLEAR_CYCLES - 1))
                         w_state_nxt = (r_num_steps == '0) ? DONE : STEP;
            STEP:    if (r_settle != '0)  w_state_nxt = SETTLE;
                     else if (w_run_last) w_state_nxt = DONE;
            SETTLE:  if (w_step_done) w_state_nxt = w_run_last ? DONE : STEP;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_abort) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_num_steps  <= '0;
            r_settle     <= '0;
            r_step_count <= '0;
            r_clr_cnt    <= '0;
            r_settle_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_num_steps  <= num_steps;
                r_settle     <= settle_cycles;
                r_step_count <= '0;
            end else if (w_step_done && !w_abort) begin
                r_step_count <= w_step_next;
            end
            r_clr_cnt    <= (r_state == CLEAR)  ? r_clr_cnt + 1'b1    : '0;
            r_settle_cnt <= (r_state == SETTLE) ? r_settle_cnt + 1'b1 : '0;
        end
    end

`ifdef SNN_SCHED_WINNER_EN
    logic [NUM_OUTPUTS-1:0][COUNT_W-1:0] w_cnt_all;
`endif

    snn_sat_counter_bank #(
        .NUM_OUTPUTS (NUM_OUTPUTS),
        .COUNT_W     (COUNT_W)
    ) u_cnt_bank (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_start_acc),
        .i_en      (w_acc_en),
        .i_spike   (spike_out),
        .i_rd_idx  (cnt_rd_idx),
        .o_rd_data (cnt_rd_data),
`ifdef SNN_SCHED_WINNER_EN
        .o_cnt_all (w_cnt_all)
`else
        .o_cnt_all ()
`endif
    );

`ifdef SNN_SCHED_WINNER_EN
    logic [IDX_W-1:0]   w_arg_idx;
    logic [COUNT_W-1:0] w_arg_val;
    logic [IDX_W-1:0]   r_winner_idx;
    logic               r_winner_vld;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        w_arg_idx = '0;
        w_arg_val = w_cnt_all[0];
        for (int i = 1; i < NUM_OUTPUTS; i++) begin
            if (w_cnt_all[i] > w_arg_val) begin
                w_arg_val = w_cnt_all[i];
                w_arg_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_winner_idx <= '0;
            r_winner_vld <= 1'b0;
        end else if (w_start_acc || w_abort) begin
            r_winner_vld <= 1'b0;
        end else if (r_state == DONE) begin
            r_winner_idx <= w_arg_idx;
            r_winner_vld <= 1'b1;
        end
    end

    assign winner_idx   = r_winner_idx;
    assign winner_valid = r_winner_vld;
`else
    assign winner_idx   = '0;
    assign winner_valid = 1'b0;
`endif

    assign snn_rst    = rst || (r_state == CLEAR);
    assign step_en    = (r_state == STEP);
    assign mem_addr   = r_step_count;
    assign step_count = r_step_count;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE) && !abort;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Directed bench: a 3-neuron scheduler for timing/counting/abort, and a 2-neuron 4-bit one sharing stimulus for saturation.
module tb_snn_timestep_scheduler;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] num_steps;
    logic [7:0] settle_cycles;
    logic [2:0] spike;
    logic [2:0] rd_idx_a;
    logic [1:0] rd_idx_b;

    logic       snn_rst_a, step_en_a, busy_a, done_a, winner_valid_a;
    logic [7:0] mem_addr_a, step_count_a, cnt_a;
    logic [2:0] winner_idx_a;

    logic       snn_rst_b, step_en_b, busy_b, done_b, winner_valid_b;
    logic [7:0] mem_addr_b, step_count_b;
    logic [3:0] cnt_b;
    logic [1:0] winner_idx_b;

    int n_chk = 0;
    int n_bad = 0;

`ifdef SNN_SCHED_WINNER_EN
    localparam logic [2:0] WIN_IDX_EXP = 3'd1;
    localparam logic       WIN_VLD_EXP = 1'b1;
`else
    localparam logic [2:0] WIN_IDX_EXP = 3'd0;
    localparam logic       WIN_VLD_EXP = 1'b0;
`endif

    snn_timestep_scheduler #(
        .NUM_OUTPUTS(3), .STEP_W(8), .SETTLE_W(8), .COUNT_W(8), .CLEAR_CYCLES(2)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_steps(num_steps), .settle_cycles(settle_cycles),
        .snn_rst(snn_rst_a), .step_en(step_en_a), .mem_addr(mem_addr_a),
        .spike_out(spike), .cnt_rd_idx(rd_idx_a), .cnt_rd_data(cnt_a),
        .step_count(step_count_a), .busy(busy_a), .done(done_a),
        .winner_idx(winner_idx_a), .winner_valid(winner_valid_a)
    );

    snn_timestep_scheduler #(
        .NUM_OUTPUTS(2), .STEP_W(8), .SETTLE_W(8), .COUNT_W(4), .CLEAR_CYCLES(2)
    ) u_sat (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_steps(num_steps), .settle_cycles(settle_cycles),
        .snn_rst(snn_rst_b), .step_en(step_en_b), .mem_addr(mem_addr_b),
        .spike_out(spike[1:0]), .cnt_rd_idx(rd_idx_b), .cnt_rd_data(cnt_b),
        .step_count(step_count_b), .busy(busy_b), .done(done_b),
        .winner_idx(winner_idx_b), .winner_valid(winner_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic rd_a(input logic [2:0] idx, input logic [7:0] exp, input string tag);
        rd_idx_a = idx;
        #1;
        chk(tag, cnt_a, exp);
    endtask

    task automatic rd_b(input logic [1:0] idx, input logic [3:0] exp, input string tag);
        rd_idx_b = idx;
        #1;
        chk(tag, cnt_b, exp);
    endtask

    // Start a run and follow it cycle by cycle; cycle 1 is the first cycle after the start cycle.
    task automatic run(input int n, input int s, input logic [2:0] spk_a, input logic [2:0] spk_b,
                       input int sw, input int abort_at, input int poke_at, input logic abort_on_start,
                       output int done_at, output int n_rst, output int n_step, output int end_cyc);
        int last_step;
        @(negedge clk);
        num_steps     = n[7:0];
        settle_cycles = s[7:0];
        spike         = spk_a;
        start         = 1'b1;
        abort         = abort_on_start;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("winner_valid_cleared_on_start", winner_valid_a, 0);
        done_at   = -1;
        n_rst     = 0;
        n_step    = 0;
        last_step = 0;
        end_cyc   = -1;
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (snn_rst_a) n_rst++;
            if (step_en_a) begin
                chk("mem_addr", mem_addr_a, n_step);
                if (n_step > 0) chk("step_gap", cyc - last_step, s + 1);
                spike     = (n_step < sw) ? spk_a : spk_b;
                last_step = cyc;
                n_step++;
                if (n_step == abort_at) abort = 1'b1;
            end
            if (cyc == poke_at) begin
                start     = 1'b1;
                num_steps = 8'd1;
            end
            if (done_a) done_at = cyc;
            if (done_a || !busy_a) begin
                end_cyc = cyc;
                break;
            end
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
        end
        if (end_cyc < 0) chk("run_timeout_busy", busy_a, 0);
        @(negedge clk);
        chk("post_run_done_low", done_a, 0);
        chk("post_run_idle", busy_a, 0);
    endtask

    initial begin
        int d, r, st, e;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        num_steps = 8'd0; settle_cycles = 8'd0; spike = 3'b000;
        rd_idx_a = 3'd0; rd_idx_b = 2'd0;

        repeat (2) @(negedge clk);
        chk("rst_snn_rst", snn_rst_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_step_en", step_en_a, 0);
        chk("rst_step_count", step_count_a, 0);
        chk("rst_mem_addr", mem_addr_a, 0);
        chk("rst_cnt0", cnt_a, 0);
        chk("rst_winner_valid", winner_valid_a, 0);
        chk("rst_busy_b", busy_b, 0);
        rst = 1'b0;
        #1;
        chk("rst_release_snn_rst", snn_rst_a, 0);

        // 3 steps, no settle, neuron 0 always firing
        run(3, 0, 3'b001, 3'b001, 1000, 0, 0, 1'b0, d, r, st, e);
        chk("t1_done_cycle", d, 6);
        chk("t1_clear_cycles", r, 2);
        chk("t1_num_step_en", st, 3);
        chk("t1_step_count", step_count_a, 3);
        rd_a(3'd0, 8'd3, "t1_cnt0");
        rd_a(3'd1, 8'd0, "t1_cnt1");
        repeat (3) @(negedge clk);
        chk("t1_hold_step_count", step_count_a, 3);
        rd_a(3'd0, 8'd3, "t1_hold_cnt0");

        // 2 steps, settle 4: 5 cycles per step
        run(2, 4, 3'b011, 3'b011, 1000, 0, 0, 1'b0, d, r, st, e);
        chk("t2_done_cycle", d, 13);
        chk("t2_num_step_en", st, 2);
        rd_a(3'd0, 8'd10, "t2_cnt0");
        rd_a(3'd1, 8'd10, "t2_cnt1");
        rd_a(3'd2, 8'd0, "t2_cnt2");

        // 20 steps, all firing: 8-bit counts 20, 4-bit counts pin at 15
        run(20, 0, 3'b111, 3'b111, 1000, 0, 0, 1'b0, d, r, st, e);
        chk("t3_done_cycle", d, 23);
        chk("t3_step_count", step_count_a, 20);
        rd_a(3'd0, 8'd20, "t3_cnt0_wide");
        rd_a(3'd3, 8'd0, "t3_rd_out_of_range_a");
        rd_b(2'd0, 4'd15, "t3_sat_cnt0");
        rd_b(2'd1, 4'd15, "t3_sat_cnt1");
        rd_b(2'd2, 4'd0, "t3_rd_out_of_range_b");

        // zero-step run
        run(0, 0, 3'b111, 3'b111, 1000, 0, 0, 1'b0, d, r, st, e);
        chk("t4_done_cycle", d, 3);
        chk("t4_clear_cycles", r, 2);
        chk("t4_num_step_en", st, 0);
        chk("t4_step_count", step_count_a, 0);
        rd_a(3'd0, 8'd0, "t4_cnt0");

        // winner: counts {3,7,7}, tie resolves low
        run(7, 0, 3'b111, 3'b110, 3, 0, 0, 1'b0, d, r, st, e);
        chk("tw_done_cycle", d, 10);
        rd_a(3'd0, 8'd3, "tw_cnt0");
        rd_a(3'd1, 8'd7, "tw_cnt1");
        rd_a(3'd2, 8'd7, "tw_cnt2");
        chk("tw_winner_valid", winner_valid_a, WIN_VLD_EXP);
        chk("tw_winner_idx", winner_idx_a, WIN_IDX_EXP);

        // abort on 3rd step strobe; start poked during CLEAR with a different length
        run(10, 0, 3'b001, 3'b001, 1000, 3, 2, 1'b0, d, r, st, e);
        chk("t5_no_done", d, -1);
        chk("t5_num_step_en", st, 3);
        chk("t5_idle_cycle", e, 6);
        chk("t5_step_count", step_count_a, 2);
        rd_a(3'd0, 8'd2, "t5_cnt0");
        repeat (3) @(negedge clk);
        chk("t5_stays_idle", busy_a, 0);

        // start with abort in IDLE: start wins
        run(1, 0, 3'b010, 3'b010, 1000, 0, 0, 1'b1, d, r, st, e);
        chk("t6_done_cycle", d, 4);
        chk("t6_step_count", step_count_a, 1);
        rd_a(3'd1, 8'd1, "t6_cnt1");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
